// File: rtl/calc_pkg.sv
// calc_pkg: shared function codes, FSM state type and result-field packing for calculator_seq
package calc_pkg;
  localparam logic [2:0] FUNC_ADD = 3'b000;
  localparam logic [2:0] FUNC_SUB = 3'b001;
  localparam logic [2:0] FUNC_MUL = 3'b010;
  localparam logic [2:0] FUNC_DIV = 3'b011;
  localparam logic [2:0] FUNC_AND = 3'b100;
  localparam logic [2:0] FUNC_OR  = 3'b101;
  localparam logic [2:0] FUNC_XOR = 3'b110;
  localparam logic [2:0] FUNC_SHL = 3'b111;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  // Quotient in the low w bits, remainder directly above it; callers truncate to their result width.
  function automatic logic [63:0] div_pack(input logic [15:0] q, input logic [15:0] r, input int w);
    return (64'(r) << w) | 64'(q);
  endfunction
endpackage

// File: rtl/calculator_seq_if.sv
// calculator_seq_if: board-side operand/command bundle and status/result bundle
//   button, func, num1, num2 : towards the calculator (master drives)
//   cal_result, busy, done, err : from the calculator (slave drives)
interface calculator_seq_if #(parameter int W = 8, parameter int RES_W = 32);
  logic             button;
  logic [2:0]       func;
  logic [W-1:0]     num1;
  logic [W-1:0]     num2;
  logic [RES_W-1:0] cal_result;
  logic             busy;
  logic             done;
  logic             err;
  modport master(output button, func, num1, num2, input cal_result, busy, done, err);
  modport slave(input button, func, num1, num2, output cal_result, busy, done, err);
endinterface

// File: rtl/button_debounce.sv
// button_debounce: 2-flop synchroniser plus stable-count debounce with rising-edge pulse
//   clk, rst (async, active-low), btn_in (raw, asynchronous)
//   level : debounced button level
//   rise  : one-cycle pulse in the first cycle level reads 1
module button_debounce #(parameter int DEB_CYCLES = 100000) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic level,
  output logic rise
);
  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);
  logic s1, s2;
  logic [CW-1:0] cnt;
  if (DEB_CYCLES < 1) begin : g_deb_chk
    $error("DEB_CYCLES must be >= 1");
  end
  // cnt counts consecutive cycles the synced level has disagreed with level; any agreement restarts it.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      level <= 1'b0;
      rise <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= btn_in;
      s2 <= s1;
      rise <= s2 && !level && cnt == LAST;
      level <= (s2 != level && cnt == LAST) ? s2 : level;
      cnt <= (s2 == level || cnt == LAST) ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/calculator_seq.sv
// calculator_seq: debounced-button-triggered W-bit calculator with iterative mul/div
//   clk, rst (async, active-low)
//   bus.button : raw start button; bus.func/num1/num2 : sampled on start
//   bus.cal_result : last completed result; bus.busy/done/err : status
module calculator_seq import calc_pkg::*; #(
  parameter int W = 8,
  parameter int RES_W = 32,
  parameter int DEB_CYCLES = 100000
) (
  input logic clk,
  input logic rst,
  calculator_seq_if.slave bus
);
  localparam int CW = $clog2(W + 1);
  if (W < 4 || W > 16) begin : g_w_chk
    $error("W must be in 4..16");
  end
  if (RES_W < 2 * W) begin : g_res_chk
    $error("RES_W must be >= 2*W");
  end
  state_t state;
  logic start, level, rise, busy, done, err, ge, div0, iter;
  logic [2:0] fn;
  logic [W-1:0] a_r, b_r, rem, rem_n, quo_n;
  logic [W:0] sh;
  logic [RES_W-1:0] acc, mc, res, acc_n, alu, ea, eb;
  logic [CW-1:0] cnt;
  button_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
    .clk(clk), .rst(rst), .btn_in(bus.button), .level(level), .rise(rise)
  );
  assign start = rise & level;
  // mul: mc holds the shifted multiplicand, b_r shifts right as the multiplier.
  // div: a_r shifts left and collects quotient bits, rem is the partial remainder.
  always_comb begin
    ea = RES_W'(a_r);
    eb = RES_W'(b_r);
    acc_n = b_r[0] ? acc + mc : acc;
    sh = {rem, a_r[W-1]};
    ge = sh >= {1'b0, b_r};
    rem_n = ge ? W'(sh - {1'b0, b_r}) : sh[W-1:0];
    quo_n = {a_r[W-2:0], ge};
    div0 = fn == FUNC_DIV && b_r == '0;
    iter = fn == FUNC_MUL || (fn == FUNC_DIV && !div0);
    alu = fn == FUNC_ADD ? ea + eb :
          fn == FUNC_SUB ? ea - eb :
          fn == FUNC_AND ? ea & eb :
          fn == FUNC_OR  ? ea | eb :
          fn == FUNC_XOR ? ea ^ eb :
          fn == FUNC_SHL ? (32'(b_r) >= RES_W ? '0 : ea << b_r) :
          div0 ? RES_W'(div_pack(16'({W{1'b1}}), 16'(a_r), W)) : '0;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      res <= '0;
      fn <= FUNC_ADD;
      a_r <= '0;
      b_r <= '0;
      acc <= '0;
      mc <= '0;
      rem <= '0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= CALC;
          busy <= 1'b1;
          fn <= bus.func;
          a_r <= bus.num1;
          b_r <= bus.num2;
          acc <= '0;
          mc <= RES_W'(bus.num1);
          rem <= '0;
          cnt <= CW'(W);
        end
        CALC: if (!iter) begin
          state <= DONE;
          busy <= 1'b0;
          done <= 1'b1;
          res <= alu;
          err <= div0;
        end else begin
          acc <= acc_n;
          mc <= mc << 1;
          b_r <= fn == FUNC_MUL ? b_r >> 1 : b_r;
          a_r <= quo_n;
          rem <= rem_n;
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state <= DONE;
            busy <= 1'b0;
            done <= 1'b1;
            err <= 1'b0;
            res <= fn == FUNC_MUL ? acc_n : RES_W'(div_pack(16'(quo_n), 16'(rem_n), W));
          end
        end
        DONE: begin
          state <= IDLE;
          done <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  assign bus.cal_result = res;
  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.err = err;
endmodule
